// File: rtl/hs_tx_master.sv
// hs_tx_master: transmit side of a valid/ready handshake.
// Words from the local write port are queued in a small circular FIFO and
// presented downstream through a registered valid_out/data_out stage. Once
// valid_out is raised, valid_out and data_out hold until a transfer occurs.
// Optional build macro: HS_TX_GAP_EN. When it is defined, one idle cycle is
// inserted after every transfer, which limits throughput to one beat per two
// cycles.
// DEPTH must be a power of two and at least 2. The pointers wrap naturally,
// so this block does not guard against other DEPTH values.
module hs_tx_master #(
    parameter int DATA_W = 3,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              overflow,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    input  logic              ready_in,
    output logic [CNT_W-1:0]  sent_cnt,
    output logic              busy
);

    localparam int PTR_W  = $clog2(DEPTH);
    // The occupancy count needs one extra bit so that it can represent DEPTH.
    localparam int FCNT_W = PTR_W + 1;

    localparam logic [FCNT_W-1:0] FCNT_DEPTH = FCNT_W'(DEPTH);
    localparam logic [FCNT_W-1:0] FCNT_ZERO  = FCNT_W'(1'b0);
    localparam logic [FCNT_W-1:0] FCNT_ONE   = FCNT_W'(1'b1);
    localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0]  SENT_ONE   = CNT_W'(1'b1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
`ifdef HS_TX_GAP_EN
    localparam logic [1:0] ST_GAP  = 2'd2;
`endif

    // Storage and state registers
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [FCNT_W-1:0] count_r;
    logic [1:0]        state_r;
    logic              valid_r;
    logic [DATA_W-1:0] data_r;
    logic              full_r;
    logic              overflow_r;
    logic [CNT_W-1:0]  sent_cnt_r;
    logic              busy_r;

    // Next-state and control signals
    logic              push_s;
    logic              pop_s;
    logic              xfer_s;
    logic              fifo_empty_s;
    logic [1:0]        state_nxt_s;
    logic              valid_nxt_s;
    logic [FCNT_W-1:0] count_nxt_s;

    assign full      = full_r;
    assign overflow  = overflow_r;
    assign valid_out = valid_r;
    assign data_out  = data_r;
    assign sent_cnt  = sent_cnt_r;
    assign busy      = busy_r;

    // Handshake qualifiers. A write is judged only against the registered full
    // flag, so a pop in the same cycle does not make room for it.
    always_comb begin
        push_s       = wr_en & ~full_r;
        xfer_s       = valid_r & ready_in;
        fifo_empty_s = (count_r == FCNT_ZERO);
    end

    // Output-stage FSM: decides when to pop the FIFO head into the output
    // register and when valid_out changes.
    always_comb begin
        state_nxt_s = state_r;
        valid_nxt_s = valid_r;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s       = 1'b1;
                    valid_nxt_s = 1'b1;
                    state_nxt_s = ST_SEND;
                end else begin
                    valid_nxt_s = 1'b0;
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (!xfer_s) begin
                    // Hold valid and data until the receiver accepts the beat.
                    valid_nxt_s = 1'b1;
                    state_nxt_s = ST_SEND;
`ifdef HS_TX_GAP_EN
                end else begin
                    valid_nxt_s = 1'b0;
                    state_nxt_s = ST_GAP;
                end
`else
                end else if (!fifo_empty_s) begin
                    // Back-to-back beat: load the next word in the transfer cycle.
                    pop_s       = 1'b1;
                    valid_nxt_s = 1'b1;
                    state_nxt_s = ST_SEND;
                end else begin
                    valid_nxt_s = 1'b0;
                    state_nxt_s = ST_IDLE;
                end
`endif
            end
`ifdef HS_TX_GAP_EN
            ST_GAP: begin
                // The gap lasts one cycle. Leaving it makes the same choice
                // that IDLE would make, so the next beat follows immediately
                // after the gap.
                if (!fifo_empty_s) begin
                    pop_s       = 1'b1;
                    valid_nxt_s = 1'b1;
                    state_nxt_s = ST_SEND;
                end else begin
                    valid_nxt_s = 1'b0;
                    state_nxt_s = ST_IDLE;
                end
            end
`endif
            default: begin
                valid_nxt_s = 1'b0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FIFO occupancy. A simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + FCNT_ONE;
            2'b01:   count_nxt_s = count_r - FCNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO storage and pointers. Reset clears stale words so that none can
    // reappear after reset.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= FCNT_ZERO;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
        end
    end

    // Output register and FSM state. data_out changes only when a word is
    // popped into it.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
            data_r  <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            valid_r <= valid_nxt_s;
            if (pop_s) begin
                data_r <= mem_r[rd_ptr_r];
            end
        end
    end

    // Registered status flags. These are derived from next-cycle values so
    // that they stay consistent with count_r and valid_out.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            full_r <= (count_nxt_s == FCNT_DEPTH);
            busy_r <= (count_nxt_s != FCNT_ZERO) | valid_nxt_s;
            if (wr_en && full_r) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Completed-transfer counter. It wraps at 2^CNT_W.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sent_cnt_r <= {CNT_W{1'b0}};
        end else if (xfer_s) begin
            sent_cnt_r <= sent_cnt_r + SENT_ONE;
        end
    end

endmodule

// File: tb/tb_hs_tx_master.sv
// Directed testbench for hs_tx_master (default parameters: DATA_W=3,
// DEPTH=4, CNT_W=8). Inputs change 1 time unit after a rising edge, and
// outputs are checked at that same point, after the edge has settled.
module tb_hs_tx_master;

    logic       sys_clk;
    logic       sys_rst;
    logic       wr_en;
    logic [2:0] wr_data;
    logic       full;
    logic       overflow;
    logic       valid_out;
    logic [2:0] data_out;
    logic       ready_in;
    logic [7:0] sent_cnt;
    logic       busy;

    int checks = 0;
    int errors = 0;
    logic [5:0] vpat;

    hs_tx_master #(.DATA_W(3), .DEPTH(4), .CNT_W(8)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .overflow  (overflow),
        .valid_out (valid_out),
        .data_out  (data_out),
        .ready_in  (ready_in),
        .sent_cnt  (sent_cnt),
        .busy      (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL timeout observed no_finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic pulse_reset();
        sys_rst = 1'b1;
        #2;
        sys_rst = 1'b0;
    endtask

    initial begin
        sys_rst = 1'b1; wr_en = 1'b0; wr_data = 3'd0; ready_in = 1'b0;
        #2;
        chk("rst_valid", valid_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_sent", sent_cnt, 0);
        chk("rst_busy", busy, 0);
        tick();
        sys_rst = 1'b0;

        // Test 1: write 3,2,3 with ready_in=1.
        ready_in = 1'b1; wr_en = 1'b1; wr_data = 3'd3;
        tick();
        chk("t1_lat_valid", valid_out, 0);
        chk("t1_lat_busy", busy, 1);
        wr_data = 3'd2;
        tick();
        chk("t1_v0", valid_out, 1);
        chk("t1_d0", data_out, 3);
        wr_data = 3'd3;
        tick();
        chk("t1_d1", data_out, 2);
        wr_en = 1'b0;
        tick();
        chk("t1_d2", data_out, 3);
        chk("t1_v2", valid_out, 1);
        tick();
        chk("t1_end_valid", valid_out, 0);
        chk("t1_sent", sent_cnt, 3);
        chk("t1_busy", busy, 0);

        // Test 2: the beat is held while ready_in is low.
        pulse_reset();
        ready_in = 1'b0; wr_en = 1'b1; wr_data = 3'd5;
        tick();
        wr_en = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("t2_hold_valid", valid_out, 1);
            chk("t2_hold_data", data_out, 5);
            tick();
        end
        chk("t2_hold_sent", sent_cnt, 0);
        ready_in = 1'b1;
        tick();
        chk("t2_valid_after", valid_out, 0);
        chk("t2_sent", sent_cnt, 1);
        tick();
        chk("t2_sent_once", sent_cnt, 1);

        // Test 3: six writes with ready_in low. Word 6 is rejected.
        pulse_reset();
        ready_in = 1'b0; wr_en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            wr_data = k[2:0];
            tick();
        end
        chk("t3_full", full, 1);
        chk("t3_ovf_pre", overflow, 0);
        wr_data = 3'd6;
        tick();
        chk("t3_ovf", overflow, 1);
        chk("t3_head", data_out, 1);
        wr_en = 1'b0; ready_in = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            tick();
            chk("t3_order_valid", valid_out, 1);
            chk("t3_order_data", data_out, k);
        end
        tick();
        chk("t3_drained", valid_out, 0);
        chk("t3_sent", sent_cnt, 5);
        chk("t3_ovf_sticky", overflow, 1);

        // Test 4: a write while full is rejected even though a pop happens
        // in the same cycle. The write on the next cycle is accepted.
        pulse_reset();
        ready_in = 1'b0; wr_en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            wr_data = k[2:0];
            tick();
        end
        chk("t4_full", full, 1);
        ready_in = 1'b1; wr_data = 3'd7;
        tick();
        chk("t4_full_drop", full, 0);
        chk("t4_ovf", overflow, 1);
        chk("t4_d", data_out, 2);
        tick();
        chk("t4_d3", data_out, 3);
        wr_en = 1'b0;
        tick();
        chk("t4_d4", data_out, 4);
        tick();
        chk("t4_d5", data_out, 5);
        tick();
        chk("t4_d7", data_out, 7);
        tick();
        chk("t4_end", valid_out, 0);
        chk("t4_sent", sent_cnt, 6);

        // Test 5: an asynchronous reset asserted in mid-stream.
        ready_in = 1'b0; wr_en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            wr_data = k[2:0];
            tick();
        end
        wr_en = 1'b0;
        chk("t5_pre_full", full, 1);
        chk("t5_pre_valid", valid_out, 1);
        sys_rst = 1'b1;
        #1;
        chk("t5_async_valid", valid_out, 0);
        chk("t5_async_full", full, 0);
        chk("t5_async_sent", sent_cnt, 0);
        chk("t5_async_busy", busy, 0);
        #1;
        sys_rst = 1'b0;
        ready_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_no_stale", valid_out, 0);
            chk("t5_no_busy", busy, 0);
        end

        // Test 6: valid_out pattern for three pushed words.
`ifdef HS_TX_GAP_EN
        vpat = 6'b101010;
`else
        vpat = 6'b001110;
`endif
        pulse_reset();
        ready_in = 1'b1; wr_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wr_data = 3'(k + 1);
            if (k >= 3) wr_en = 1'b0;
            tick();
            chk("t6_vpat", valid_out, vpat[k]);
        end
        tick();
        tick();
        chk("t6_sent", sent_cnt, 3);

        // Test 7: sent_cnt wraps from 255 back to 0.
        pulse_reset();
        ready_in = 1'b1; wr_en = 1'b1;
        for (int i = 0; i < 255; i++) begin
            wr_data = i[2:0];
            tick();
        end
        wr_en = 1'b0;
        for (int k = 0; k < 10 && valid_out; k++) begin
            tick();
        end
        chk("t7_drain", valid_out, 0);
        chk("t7_sent255", sent_cnt, 255);
        chk("t7_no_ovf", overflow, 0);
        wr_en = 1'b1; wr_data = 3'd4;
        tick();
        wr_en = 1'b0;
        tick();
        chk("t7_last_data", data_out, 4);
        chk("t7_pre_wrap", sent_cnt, 255);
        tick();
        chk("t7_wrap", sent_cnt, 0);
        chk("t7_idle", valid_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
